reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/reg_scoreboard.sv | 42 ++++
 rtl/reg_file.sv | 82 ++++++++
 tb/tb_reg_file.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I integer-core constants: word width, register count, index width.
// Pure declarations, no logic; imported by the register file and its scoreboard.
// No flow control of its own.
package rv32i_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t X0_IDX = reg_idx_t'(0);

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set on issue, clear on writeback, combinational lookup for both read ports.
// Set/clear take effect at the next clk edge; lookup is zero latency.
// No backpressure; the consumer of the lookup decides whether to stall.
module reg_scoreboard #(
    parameter int NREGS = rv32i_pkg::NREGS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              set_en,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   set_idx,
    input  logic                              clr_en,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   clr_idx,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   rs1_idx,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   rs2_idx,
    output logic                              rs1_pend,
    output logic                              rs2_pend
);
    import rv32i_pkg::*;

    logic [NREGS-1:0] pend;

    // Set is checked before clear so a same-cycle issue to the register being
    // written back leaves it pending: the newer producer still owes a result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && set_idx == reg_idx_t'(i)) begin
                    pend[i] <= 1'b1;
                end else if (clr_en && clr_idx == reg_idx_t'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    assign rs1_pend = pend[rs1_idx];
    assign rs2_pend = pend[rs2_idx];

endmodule

// File: rtl/reg_file.sv
// Two-read one-write integer register file with writeback bypass and issue-hazard detection.
// Reads are zero latency (bypassed from wr_data); writes land at the next clk edge.
// hazard tells upstream to stall; writes and issues are always accepted.
module reg_file #(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int NREGS = rv32i_pkg::NREGS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   rs1_addr,
    input  logic                              rs1_ren,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   rs2_addr,
    input  logic                              rs2_ren,
    output logic [XLEN-1:0]                   rs1_data,
    output logic [XLEN-1:0]                   rs2_data,
    input  logic                              wr_en,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   wr_addr,
    input  logic [XLEN-1:0]                   wr_data,
    input  logic                              issue_en,
    input  logic [rv32i_pkg::REG_IDX_W-1:0]   issue_rd,
    output logic                              hazard
);
    import rv32i_pkg::*;

    logic [XLEN-1:0] regs [NREGS];
    logic            rs1_pend;
    logic            rs2_pend;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            rs1_byp;
    logic            rs2_byp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != X0_IDX) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_byp = wr_en && (wr_addr == rs1_addr);
    assign rs2_byp = wr_en && (wr_addr == rs2_addr);

    // x0 is filtered here rather than relying on regs[0], so a write to x0
    // can never leak out through the bypass path either.
    always_comb begin
        rs1_data = '0;
        if (rst_n && rs1_addr != X0_IDX) begin
            rs1_data = rs1_byp ? wr_data : regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rst_n && rs2_addr != X0_IDX) begin
            rs2_data = rs2_byp ? wr_data : regs[rs2_addr];
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue_en),
        .set_idx  (issue_rd),
        .clr_en   (wr_en),
        .clr_idx  (wr_addr),
        .rs1_idx  (rs1_addr),
        .rs2_idx  (rs2_addr),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend)
    );

    // A pending operand whose producer writes back this cycle is served by the bypass.
    assign rs1_haz = rs1_ren && rs1_addr != X0_IDX && rs1_pend && !rs1_byp;
    assign rs2_haz = rs2_ren && rs2_addr != X0_IDX && rs2_pend && !rs2_byp;
    assign hazard  = rst_n && (rs1_haz || rs2_haz);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, x0, bypass, pending-bit hazards.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic        rs1_ren;
    logic [4:0]  rs2_addr;
    logic        rs2_ren;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        hazard;

    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs1_ren  (rs1_ren),
        .rs2_addr (rs2_addr),
        .rs2_ren  (rs2_ren),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .hazard   (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rs1_addr = 5'd0;  rs1_ren = 1'b0;
        rs2_addr = 5'd0;  rs2_ren = 1'b0;
        wr_en    = 1'b0;  wr_addr = 5'd0;  wr_data = 32'h0;
        issue_en = 1'b0;  issue_rd = 5'd0;

        // Reset held: outputs forced to zero.
        tick(); tick();
        rs1_addr = 5'd5; rs1_ren = 1'b1; rs2_addr = 5'd31; rs2_ren = 1'b1;
        settle();
        chk("rst_rs1_data", rs1_data, 32'h0);
        chk("rst_rs2_data", rs2_data, 32'h0);
        chk("rst_hazard", {31'h0, hazard}, 32'h0);

        // Out of reset: registers cleared, nothing pending.
        rst_n = 1'b1;
        settle();
        chk("post_rst_rs1", rs1_data, 32'h0);
        chk("post_rst_rs2", rs2_data, 32'h0);
        chk("post_rst_hazard", {31'h0, hazard}, 32'h0);

        // Write x5, read it back the following cycle.
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0; rs1_addr = 5'd5;
        settle();
        chk("wr_x5_rd", rs1_data, 32'hDEADBEEF);

        // Write to x0 is discarded and not bypassed.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs2_addr = 5'd0;
        settle();
        chk("x0_no_bypass", rs2_data, 32'h0);
        tick();
        wr_en = 1'b0;
        settle();
        chk("x0_rd", rs2_data, 32'h0);
        chk("x0_hazard", {31'h0, hazard}, 32'h0);

        // Same-cycle bypass of x7 on port 1, port 2 reads x5 independently.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rs1_addr = 5'd7; rs2_addr = 5'd5;
        settle();
        chk("bypass_x7", rs1_data, 32'h12345678);
        chk("indep_rs2_x5", rs2_data, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        settle();
        chk("stored_x7", rs1_data, 32'h12345678);

        // Issue x3: pending from the next cycle, cleared by its writeback.
        issue_en = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3; rs1_ren = 1'b1;
        rs2_addr = 5'd0; rs2_ren = 1'b0;
        settle();
        chk("x3_issue_cycle_hazard", {31'h0, hazard}, 32'h0);
        tick();
        issue_en = 1'b0;
        settle();
        chk("x3_pending_hazard", {31'h0, hazard}, 32'h1);
        rs1_ren = 1'b0;
        settle();
        chk("x3_ren0_hazard", {31'h0, hazard}, 32'h0);
        rs1_ren = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
        settle();
        chk("x3_wb_hazard", {31'h0, hazard}, 32'h0);
        chk("x3_wb_bypass", rs1_data, 32'hCAFEF00D);
        tick();
        wr_en = 1'b0;
        settle();
        chk("x3_cleared_hazard", {31'h0, hazard}, 32'h0);
        chk("x3_stored", rs1_data, 32'hCAFEF00D);

        // Issue and writeback of x4 in the same cycle: issue wins.
        rs1_ren = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00000044;
        tick();
        issue_en = 1'b0; wr_en = 1'b0;
        rs2_addr = 5'd4; rs2_ren = 1'b0;
        settle();
        chk("x4_ren0_hazard", {31'h0, hazard}, 32'h0);
        rs2_ren = 1'b1;
        settle();
        chk("x4_still_pending", {31'h0, hazard}, 32'h1);
        chk("x4_data", rs2_data, 32'h00000044);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00000055;
        tick();
        wr_en = 1'b0;
        settle();
        chk("x4_cleared", {31'h0, hazard}, 32'h0);

        // Set x6 and clear x8 in the same cycle are independent.
        rs2_ren = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd8;
        tick();
        issue_rd = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h00000088;
        tick();
        issue_en = 1'b0; wr_en = 1'b0;
        rs1_addr = 5'd6; rs1_ren = 1'b1;
        settle();
        chk("x6_set", {31'h0, hazard}, 32'h1);
        rs1_ren = 1'b0; rs2_addr = 5'd8; rs2_ren = 1'b1;
        settle();
        chk("x8_cleared", {31'h0, hazard}, 32'h0);
        chk("x8_data", rs2_data, 32'h00000088);

        // Reset mid-operation: state cleared, writes and issues ignored.
        rs2_ren = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 1'b0; issue_en = 1'b1; issue_rd = 5'd10;
        tick();
        issue_en = 1'b0;
        rs1_addr = 5'd10; rs1_ren = 1'b1;
        settle();
        chk("x10_pending_pre_rst", {31'h0, hazard}, 32'h1);
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11111111;
        issue_en = 1'b1; issue_rd = 5'd12;
        rs2_addr = 5'd9;
        settle();
        chk("in_rst_hazard", {31'h0, hazard}, 32'h0);
        chk("in_rst_rs2", rs2_data, 32'h0);
        tick();
        rst_n = 1'b1; wr_en = 1'b0; issue_en = 1'b0;
        settle();
        chk("x9_after_rst", rs2_data, 32'h0);
        chk("x10_hazard_after_rst", {31'h0, hazard}, 32'h0);
        rs1_addr = 5'd12;
        settle();
        chk("x12_issue_ignored", {31'h0, hazard}, 32'h0);
        rs1_addr = 5'd6;
        settle();
        chk("x6_cleared_by_rst", {31'h0, hazard}, 32'h0);
        rs2_addr = 5'd5;
        settle();
        chk("x5_after_rst", rs2_data, 32'h0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
